// File: rtl/mux_rr_nx1_pkg.sv
// Shared helpers for the round-robin N:1 output mux and its arbiter.
package mux_rr_nx1_pkg;

    // Modular add for channel indices; both operands are already below n,
    // so a single conditional subtract replaces a divider.
    function automatic int unsigned wrap_add(
        input int unsigned a,
        input int unsigned b,
        input int unsigned n
    );
        int unsigned s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/mux_rr_nx1_rr_arbiter_n.sv
// Combinational N-way arbiter: rotating priority starting at ptr, or fixed
// priority (lowest index wins) when rr_mode is 0. Grant is one-hot or zero.
module rr_arbiter_n
    import mux_rr_nx1_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            rr_mode,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx,
    output logic            grant_valid
);

    int unsigned search_idx;

    // Walk the priority order once; the first requesting channel takes the grant.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        search_idx  = 0;
        for (int k = 0; k < N; k++) begin
            if (rr_mode)
                search_idx = wrap_add(32'(ptr), 32'(k), 32'(N));
            else
                search_idx = 32'(k);
            for (int i = 0; i < N; i++) begin
                if (!grant_valid && req[i] && (32'(i) == search_idx)) begin
                    grant[i]    = 1'b1;
                    grant_idx   = SELW'(i);
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_rr_nx1.sv
// N:1 registered bus merge with per-channel valid/ready.
//
// Handshake: a word moves on a rising edge when valid and ready are both 1 in
// that cycle. in_ready is a function of the output register state, out_ready,
// in_valid, force_en/force_sel and ptr only; it never feeds back on itself.
// out_valid stays high until out_ready is seen; out_data/out_src are stable
// while out_valid && !out_ready.
module mux_rr_nx1
    import mux_rr_nx1_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N       = 4,
    parameter int SELW    = 2,
    parameter int RR_MODE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic               force_en,
    input  logic [SELW-1:0]    force_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_src
);

    logic [SELW-1:0]  ptr;
    logic [N-1:0]     eligible;
    logic [N-1:0]     grant;
    logic [SELW-1:0]  grant_idx;
    logic             grant_valid;
    logic             load_ok;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    // Forcing narrows the request set to one channel; an out-of-range
    // force_sel matches no channel, so nothing is eligible.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N; i++)
            eligible[i] = in_valid[i] && (!force_en || (force_sel == SELW'(i)));
    end

    rr_arbiter_n #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req         (eligible),
        .ptr         (ptr),
        .rr_mode     (RR_MODE != 0),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // The register can take a word when empty or when its word leaves this cycle.
    assign load_ok  = !out_valid || out_ready;
    assign in_ready = load_ok ? grant : '0;
    assign xfer     = load_ok && grant_valid;

    // AND-OR select of the granted channel's data (grant is one-hot or zero).
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++)
            if (grant[i])
                sel_data = in_data[i*WIDTH +: WIDTH];
    end

    // Output register: load on transfer, drain when consumed with no refill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Priority pointer moves past the winner only on arbitrated (unforced) transfers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (xfer && !force_en && (RR_MODE != 0))
            ptr <= SELW'(wrap_add(32'(grant_idx), 32'd1, 32'(N)));
    end

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Bench for mux_rr_nx1: one round-robin and one fixed-priority instance
// sharing the same stimulus, checked against a cycle model of the rules.
module tb_mux_rr_nx1;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic           force_en;
  logic [SW-1:0]  force_sel;
  logic           out_ready;

  logic [N-1:0]  rr_in_ready, fp_in_ready;
  logic          rr_out_valid, fp_out_valid;
  logic [W-1:0]  rr_out_data, fp_out_data;
  logic [SW-1:0] rr_out_src, fp_out_src;

  // clock/reset block
  always #5 clk = ~clk;

  mux_rr_nx1 #(.WIDTH(W), .N(N), .SELW(SW), .RR_MODE(1)) dut_rr (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rr_in_ready),
    .in_data(in_data), .force_en(force_en), .force_sel(force_sel),
    .out_valid(rr_out_valid), .out_ready(out_ready), .out_data(rr_out_data),
    .out_src(rr_out_src));

  mux_rr_nx1 #(.WIDTH(W), .N(N), .SELW(SW), .RR_MODE(0)) dut_fp (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(fp_in_ready),
    .in_data(in_data), .force_en(force_en), .force_sel(force_sel),
    .out_valid(fp_out_valid), .out_ready(out_ready), .out_data(fp_out_data),
    .out_src(fp_out_src));

  // reference model state
  int           m_ptr;
  bit           rr_ov, fp_ov;
  logic [W-1:0] rr_od, fp_od;
  int           rr_os, fp_os;
  logic [W-1:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Winner under the arbitration rules, or -1 when nobody is eligible.
  function automatic int pick(input logic [N-1:0] v, input bit fen, input int fsel,
                              input int start, input bit rr);
    for (int k = 0; k < N; k++) begin
      int c;
      c = rr ? (start + k) % N : k;
      if (v[c] && (!fen || fsel == c)) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] ready_of(input int g, input bit ov, input logic ordy);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0 && (!ov || ordy)) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [W-1:0] chan_word(input int i);
    return in_data[i*W +: W];
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    rr_ov = 0; fp_ov = 0;
    rr_od = '0; fp_od = '0;
    rr_os = 0; fp_os = 0;
    exp_q.delete();
  endtask

  // Advance the model by one edge using the inputs now applied, then move the
  // bench to the following falling edge.
  task automatic clock_model();
    int  g_rr, g_fp;
    g_rr = pick(in_valid, force_en, int'(force_sel), m_ptr, 1'b1);
    g_fp = pick(in_valid, force_en, int'(force_sel), 0, 1'b0);
    if ((!rr_ov || out_ready) && g_rr >= 0) begin
      rr_ov = 1; rr_od = chan_word(g_rr); rr_os = g_rr;
      exp_q.push_back(rr_od);
      if (!force_en) m_ptr = (g_rr + 1) % N;
    end else if (out_ready) begin
      rr_ov = 0;
    end
    if ((!fp_ov || out_ready) && g_fp >= 0) begin
      fp_ov = 1; fp_od = chan_word(g_fp); fp_os = g_fp;
    end else if (out_ready) begin
      fp_ov = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver task
  task automatic drive(input logic [N-1:0] v, input logic fen, input logic [SW-1:0] fsel,
                       input logic ordy);
    in_valid = v; force_en = fen; force_sel = fsel; out_ready = ordy;
  endtask

  task automatic test_reset();
    drive('0, 1'b0, '0, 1'b0);
    in_data = '0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (rr_out_valid !== 1'b0 || rr_out_data !== '0 || rr_out_src !== '0) $display("FAIL reset_outputs: got v=%b d=%h s=%0d expected v=0 d=0 s=0", rr_out_valid, rr_out_data, rr_out_src);
    else n_pass++;
    n_checks++;
    if (rr_in_ready !== 4'b0000 || fp_in_ready !== 4'b0000) $display("FAIL reset_in_ready: got rr=%b fp=%b expected 0000", rr_in_ready, fp_in_ready);
    else n_pass++;
    n_checks++;
    if (fp_out_valid !== 1'b0 || fp_out_data !== '0) $display("FAIL reset_fp_outputs: got v=%b d=%h expected v=0 d=0", fp_out_valid, fp_out_data);
    else n_pass++;
    for (int c = 0; c < 10; c++) begin
      clock_model();
      n_checks++;
      if (rr_out_valid !== 1'b0 || fp_out_valid !== 1'b0) $display("FAIL idle_valid: cycle %0d got rr=%b fp=%b expected 0", c, rr_out_valid, fp_out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'(32'h1111_1111 * i);
    drive(4'b1111, 1'b0, '0, 1'b1);
    for (int c = 0; c < 12; c++) begin
      logic [N-1:0] exp_rdy;
      exp_rdy = '0;
      exp_rdy[c % N] = 1'b1;
      #1;
      n_checks++;
      if (rr_in_ready !== exp_rdy) $display("FAIL rr_in_ready: cycle %0d got %b expected %b", c, rr_in_ready, exp_rdy);
      else n_pass++;
      clock_model();
      n_checks++;
      if (rr_out_valid !== 1'b1 || rr_out_src !== SW'(c % N) || rr_out_data !== 32'(32'h1111_1111 * (c % N)))
        $display("FAIL rr_sequence: cycle %0d got v=%b s=%0d d=%h expected v=1 s=%0d d=%h", c, rr_out_valid, rr_out_src, rr_out_data, c % N, 32'(32'h1111_1111 * (c % N)));
      else n_pass++;
    end
  endtask

  task automatic test_back_pressure();
    int g;
    g = pick(4'b1111, 1'b0, 0, m_ptr, 1'b1);
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h5000_0000 + 32'(i);
    in_data[g*W +: W] = 32'h2222_2222;
    drive(4'b1111, 1'b0, '0, 1'b1);
    clock_model();
    drive(4'b1111, 1'b0, '0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (rr_in_ready !== 4'b0000 || fp_in_ready !== 4'b0000) $display("FAIL stall_in_ready: cycle %0d got rr=%b fp=%b expected 0000", c, rr_in_ready, fp_in_ready);
      else n_pass++;
      clock_model();
      n_checks++;
      if (rr_out_valid !== 1'b1 || rr_out_data !== 32'h2222_2222 || rr_out_src !== SW'(g))
        $display("FAIL stall_hold: cycle %0d got v=%b d=%h s=%0d expected v=1 d=22222222 s=%0d", c, rr_out_valid, rr_out_data, rr_out_src, g);
      else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (rr_in_ready !== ready_of((g + 1) % N, 1'b1, 1'b1)) $display("FAIL release_in_ready: got %b expected %b", rr_in_ready, ready_of((g + 1) % N, 1'b1, 1'b1));
    else n_pass++;
    clock_model();
    n_checks++;
    if (rr_out_src !== SW'((g + 1) % N)) $display("FAIL release_src: got %0d expected %0d", rr_out_src, (g + 1) % N);
    else n_pass++;
  endtask

  task automatic test_force();
    int saved_ptr;
    saved_ptr = m_ptr;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h7000_0000 + 32'(i);
    drive(4'b1111, 1'b1, 2'd2, 1'b1);
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (rr_in_ready !== 4'b0100 || fp_in_ready !== 4'b0100) $display("FAIL force_in_ready: cycle %0d got rr=%b fp=%b expected 0100", c, rr_in_ready, fp_in_ready);
      else n_pass++;
      clock_model();
      n_checks++;
      if (rr_out_src !== 2'd2 || rr_out_data !== 32'h7000_0002) $display("FAIL force_src: cycle %0d got s=%0d d=%h expected s=2 d=70000002", c, rr_out_src, rr_out_data);
      else n_pass++;
    end
    drive(4'b1011, 1'b1, 2'd2, 1'b1);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (rr_in_ready !== 4'b0000) $display("FAIL force_idle_ready: cycle %0d got %b expected 0000", c, rr_in_ready);
      else n_pass++;
      clock_model();
      n_checks++;
      if (rr_out_valid !== 1'b0 || rr_out_src !== 2'd2) $display("FAIL force_drain: cycle %0d got v=%b s=%0d expected v=0 s=2", c, rr_out_valid, rr_out_src);
      else n_pass++;
    end
    drive(4'b1111, 1'b0, 2'd2, 1'b1);
    #1;
    n_checks++;
    if (rr_in_ready !== ready_of(saved_ptr, 1'b0, 1'b1)) $display("FAIL force_ptr_kept: got %b expected %b", rr_in_ready, ready_of(saved_ptr, 1'b0, 1'b1));
    else n_pass++;
    clock_model();
    n_checks++;
    if (rr_out_src !== SW'(saved_ptr)) $display("FAIL force_ptr_src: got %0d expected %0d", rr_out_src, saved_ptr);
    else n_pass++;
  endtask

  task automatic test_fixed_priority();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h9000_0000 + 32'(i);
    drive(4'b0110, 1'b0, '0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      #1;
      n_checks++;
      if (fp_in_ready !== 4'b0010) $display("FAIL fp_in_ready: cycle %0d got %b expected 0010", c, fp_in_ready);
      else n_pass++;
      clock_model();
      n_checks++;
      if (fp_out_valid !== 1'b1 || fp_out_src !== 2'd1 || fp_out_data !== 32'h9000_0001)
        $display("FAIL fp_winner: cycle %0d got v=%b s=%0d d=%h expected v=1 s=1 d=90000001", c, fp_out_valid, fp_out_src, fp_out_data);
      else n_pass++;
      n_checks++;
      if (rr_out_src !== SW'(rr_os)) $display("FAIL rr_alternate: cycle %0d got %0d expected %0d", c, rr_out_src, rr_os);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h3333_3333;
    drive(4'b1111, 1'b0, '0, 1'b1);
    clock_model();
    out_ready = 1'b0;
    n_checks++;
    if (rr_out_valid !== 1'b1 || rr_out_data !== 32'h3333_3333) $display("FAIL mid_loaded: got v=%b d=%h expected v=1 d=33333333", rr_out_valid, rr_out_data);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (rr_out_valid !== 1'b0 || fp_out_valid !== 1'b0 || rr_out_data !== '0) $display("FAIL mid_async_reset: got rr_v=%b fp_v=%b d=%h expected 0 0 0", rr_out_valid, fp_out_valid, rr_out_data);
    else n_pass++;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA000_0000 + 32'(i);
    drive(4'b1111, 1'b0, '0, 1'b1);
    #1;
    n_checks++;
    if (rr_in_ready !== 4'b0001) $display("FAIL post_reset_ready: got %b expected 0001", rr_in_ready);
    else n_pass++;
    clock_model();
    n_checks++;
    if (rr_out_src !== 2'd0 || rr_out_data !== 32'hA000_0000) $display("FAIL post_reset_src: got s=%0d d=%h expected s=0 d=a0000000", rr_out_src, rr_out_data);
    else n_pass++;
  endtask

  task automatic test_random();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] e_rr, e_fp;
      for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
      drive(N'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), SW'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0));
      if (rr_out_valid === 1'b1 && out_ready) begin
        logic [W-1:0] exp_w;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL sb_empty: cycle %0d got d=%h expected no word", c, rr_out_data);
        else begin
          exp_w = exp_q.pop_front();
          if (rr_out_data !== exp_w) $display("FAIL sb_data: cycle %0d got %h expected %h", c, rr_out_data, exp_w);
          else n_pass++;
        end
      end
      e_rr = ready_of(pick(in_valid, force_en, int'(force_sel), m_ptr, 1'b1), rr_ov, out_ready);
      e_fp = ready_of(pick(in_valid, force_en, int'(force_sel), 0, 1'b0), fp_ov, out_ready);
      #1;
      n_checks++;
      if (rr_in_ready !== e_rr || fp_in_ready !== e_fp) $display("FAIL rand_in_ready: cycle %0d got rr=%b fp=%b expected rr=%b fp=%b", c, rr_in_ready, fp_in_ready, e_rr, e_fp);
      else n_pass++;
      clock_model();
      n_checks++;
      if (rr_out_valid !== rr_ov || rr_out_data !== rr_od || rr_out_src !== SW'(rr_os))
        $display("FAIL rand_rr_out: cycle %0d got v=%b d=%h s=%0d expected v=%b d=%h s=%0d", c, rr_out_valid, rr_out_data, rr_out_src, rr_ov, rr_od, rr_os);
      else n_pass++;
      n_checks++;
      if (fp_out_valid !== fp_ov || fp_out_data !== fp_od || fp_out_src !== SW'(fp_os))
        $display("FAIL rand_fp_out: cycle %0d got v=%b d=%h s=%0d expected v=%b d=%h s=%0d", c, fp_out_valid, fp_out_data, fp_out_src, fp_ov, fp_od, fp_os);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = '0; in_data = '0; force_en = 1'b0; force_sel = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_back_pressure();
    test_force();
    test_fixed_priority();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
